reg_writeback: RTL and testbench

Writeback and hazard-tracking unit on the write side of the integer register file. It accepts completed results from the ALU path and the load path, arbitrates them onto the register file's single write port, and tracks pending destination registers in a scoreboard. Decode queries the scoreboard for issue stalls and operand hazards. It sits between execute/memory and the register file write port.

---
 rtl/reg_pkg.sv | 10 +
 rtl/reg_scoreboard.sv | 69 ++++++
 rtl/reg_writeback.sv | 103 ++++++++++
 tb/tb_reg_writeback.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared types and sizes for the integer register file write side.
package reg_pkg;

  localparam int unsigned NUM_REG    = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [NUM_REG-1:0]    busy_vec_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-destination scoreboard: busy vector, operand/issue queries and
// sticky detection of results that arrive for a register nobody issued.
module reg_scoreboard
  import reg_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  // issue side
  input  logic      issue_valid,
  input  reg_addr_t issue_rd,
  output logic      issue_ready,
  // clear side: the register file write itself
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  // accepted result, checked against the busy vector
  input  logic      acc_valid,
  input  reg_addr_t acc_rd,
  // decode operand queries
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  output logic      rs1_busy,
  output logic      rs2_busy,
  output logic      sb_err
);

  busy_vec_t busy_q, busy_d;
  logic      sb_err_q, sb_err_d;

  // Queries read the registered vector; bit 0 is never set so x0 reads idle.
  always_comb begin
    issue_ready = ~busy_q[issue_rd];
    rs1_busy    = busy_q[rs1_addr];
    rs2_busy    = busy_q[rs2_addr];
    sb_err      = sb_err_q;
  end

  // Clear on register file write, set on issue handshake. A same-rd set and
  // clear cannot coincide because issue_ready is low while the bit is set.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (issue_valid && issue_ready && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Sticky error: a nonzero-rd result accepted without a pending bit.
  always_comb begin
    sb_err_d = sb_err_q;
    if (acc_valid && (acc_rd != '0) && !busy_q[acc_rd]) begin
      sb_err_d = 1'b1;
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback unit: arbitrates load and ALU results onto the single register
// file write port (load first), registers the write and counts results.
module reg_writeback
  import reg_pkg::*;
#(
  parameter int unsigned REG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  output logic                 issue_ready,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [4:0]           alu_rd,
  input  logic [REG_WIDTH-1:0] alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [4:0]           ld_rd,
  input  logic [REG_WIDTH-1:0] ld_data,
  input  logic [4:0]           rs1_addr,
  input  logic [4:0]           rs2_addr,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 reg_wr_en,
  output logic [4:0]           reg_wr_addr,
  output logic [REG_WIDTH-1:0] reg_wr_data,
  output logic [REG_WIDTH-1:0] wb_cnt,
  output logic                 sb_err
);

  logic                 acc_valid;
  reg_addr_t            acc_rd;
  logic [REG_WIDTH-1:0] acc_data;

  logic                 wr_en_q, wr_en_d;
  reg_addr_t            wr_addr_q, wr_addr_d;
  logic [REG_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [REG_WIDTH-1:0] wb_cnt_q, wb_cnt_d;

  // Fixed priority: loads always accepted, ALU only when no load is present.
  always_comb begin
    ld_ready  = 1'b1;
    alu_ready = ~ld_valid;
    acc_valid = ld_valid | alu_valid;
    acc_rd    = ld_valid ? ld_rd : alu_rd;
    acc_data  = ld_valid ? ld_data : alu_data;
  end

  // Output stage next state; x0 results are counted but never written, and
  // address/data hold when no write is launched.
  always_comb begin
    wr_en_d   = acc_valid && (acc_rd != '0);
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (wr_en_d) begin
      wr_addr_d = acc_rd;
      wr_data_d = acc_data;
    end
    wb_cnt_d = wb_cnt_q + {{(REG_WIDTH-1){1'b0}}, acc_valid};
  end

  // Output register and result counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wb_cnt_q  <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wb_cnt_q  <= wb_cnt_d;
    end
  end

  // Drive registered outputs.
  always_comb begin
    reg_wr_en   = wr_en_q;
    reg_wr_addr = wr_addr_q;
    reg_wr_data = wr_data_q;
    wb_cnt      = wb_cnt_q;
  end

  reg_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .clr_en      (wr_en_q),
    .clr_addr    (wr_addr_q),
    .acc_valid   (acc_valid),
    .acc_rd      (acc_rd),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .sb_err      (sb_err)
  );

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: expected writes are queued when a
// handshake is seen and compared when the registered write appears.
module tb_reg_writeback;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         issue_valid;
  logic [4:0]   issue_rd;
  logic         issue_ready;
  logic         alu_valid;
  logic         alu_ready;
  logic [4:0]   alu_rd;
  logic [W-1:0] alu_data;
  logic         ld_valid;
  logic         ld_ready;
  logic [4:0]   ld_rd;
  logic [W-1:0] ld_data;
  logic [4:0]   rs1_addr;
  logic [4:0]   rs2_addr;
  logic         rs1_busy;
  logic         rs2_busy;
  logic         reg_wr_en;
  logic [4:0]   reg_wr_addr;
  logic [W-1:0] reg_wr_data;
  logic [W-1:0] wb_cnt;
  logic         sb_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [4:0]   addr;
    logic [W-1:0] data;
  } wr_t;

  wr_t          exp_q[$];
  logic [W-1:0] exp_cnt;

  always #5 clk = ~clk;

  reg_writeback #(.REG_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .wb_cnt      (wb_cnt),
    .sb_err      (sb_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Handshake model: load has priority, ALU only without a load.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      exp_cnt = '0;
    end else if (ld_valid) begin
      exp_cnt = exp_cnt + 1;
      if (ld_rd != 5'd0) exp_q.push_back('{addr: ld_rd, data: ld_data});
    end else if (alu_valid) begin
      exp_cnt = exp_cnt + 1;
      if (alu_rd != 5'd0) exp_q.push_back('{addr: alu_rd, data: alu_data});
    end
  end

  // Registered write must appear exactly one cycle after its handshake.
  always @(negedge clk) begin
    wr_t e;
    check("wr_en", {63'd0, reg_wr_en}, {63'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("wr_addr", {59'd0, reg_wr_addr}, {59'd0, e.addr});
      check("wr_data", {32'd0, reg_wr_data}, {32'd0, e.data});
    end
    check("wb_cnt", {32'd0, wb_cnt}, {32'd0, exp_cnt});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    issue_valid = 1'b0; issue_rd = 5'd5;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    rs1_addr = 5'd5; rs2_addr = 5'd0;

    // Reset asserted between edges takes effect immediately.
    #2 rst = 1'b1;
    #1;
    check("rst_wr_en", {63'd0, reg_wr_en}, 64'd0);
    check("rst_wr_addr", {59'd0, reg_wr_addr}, 64'd0);
    check("rst_wr_data", {32'd0, reg_wr_data}, 64'd0);
    check("rst_wb_cnt", {32'd0, wb_cnt}, 64'd0);
    check("rst_sb_err", {63'd0, sb_err}, 64'd0);
    check("rst_issue_ready", {63'd0, issue_ready}, 64'd1);
    check("rst_rs1_busy", {63'd0, rs1_busy}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc();

    // Issue rd5, then ALU result for rd5.
    issue_valid = 1'b1; issue_rd = 5'd5;
    #1 check("issue5_ready", {63'd0, issue_ready}, 64'd1);
    cyc();
    issue_valid = 1'b0; rs1_addr = 5'd5;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1 check("rs1_busy5_issued", {63'd0, rs1_busy}, 64'd1);
    check("alu_ready_alone", {63'd0, alu_ready}, 64'd1);
    cyc();
    alu_valid = 1'b0;
    #1 check("rs1_busy5_wr_cycle", {63'd0, rs1_busy}, 64'd1);
    cyc();
    #1 check("rs1_busy5_cleared", {63'd0, rs1_busy}, 64'd0);
    check("sb_err_clean", {63'd0, sb_err}, 64'd0);

    // Issue rd3, rd4; load and ALU contend.
    issue_valid = 1'b1; issue_rd = 5'd3;
    #1 check("issue3_ready", {63'd0, issue_ready}, 64'd1);
    cyc();
    issue_rd = 5'd4;
    #1 check("issue4_ready", {63'd0, issue_ready}, 64'd1);
    cyc();
    issue_valid = 1'b0;
    rs1_addr = 5'd3; rs2_addr = 5'd4;
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h11;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
    #1 check("alu_ready_blocked", {63'd0, alu_ready}, 64'd0);
    check("ld_ready", {63'd0, ld_ready}, 64'd1);
    check("rs1_busy3", {63'd0, rs1_busy}, 64'd1);
    check("rs2_busy4", {63'd0, rs2_busy}, 64'd1);
    cyc();
    ld_valid = 1'b0;
    #1 check("alu_ready_after_ld", {63'd0, alu_ready}, 64'd1);
    cyc();
    alu_valid = 1'b0;
    cyc();
    cyc();
    #1 check("rs1_busy3_clear", {63'd0, rs1_busy}, 64'd0);
    check("rs2_busy4_clear", {63'd0, rs2_busy}, 64'd0);

    // WAW stall on rd7.
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1 check("issue7_first", {63'd0, issue_ready}, 64'd1);
    cyc();
    #1 check("issue7_stall", {63'd0, issue_ready}, 64'd0);
    cyc();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    #1 check("issue7_stall_acc", {63'd0, issue_ready}, 64'd0);
    cyc();
    alu_valid = 1'b0;
    #1 check("issue7_stall_wr", {63'd0, issue_ready}, 64'd0);
    cyc();
    #1 check("issue7_ready_again", {63'd0, issue_ready}, 64'd1);
    cyc();
    issue_valid = 1'b0; rs1_addr = 5'd7;
    #1 check("rs1_busy7_reissued", {63'd0, rs1_busy}, 64'd1);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h78;
    cyc();
    ld_valid = 1'b0;
    cyc();
    cyc();
    #1 check("rs1_busy7_done", {63'd0, rs1_busy}, 64'd0);
    check("sb_err_still_clean", {63'd0, sb_err}, 64'd0);

    // x0 result: counted, never written.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
    cyc();
    alu_valid = 1'b0;
    cyc();
    #1 check("sb_err_x0", {63'd0, sb_err}, 64'd0);

    // Unissued rd9 write raises sticky error.
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    cyc();
    alu_valid = 1'b0;
    #1 check("sb_err_set", {63'd0, sb_err}, 64'd1);
    cyc();
    cyc();
    #1 check("sb_err_sticky", {63'd0, sb_err}, 64'd1);

    // Pending rd12, then reset mid-stream with a handshake in the reset cycle.
    issue_valid = 1'b1; issue_rd = 5'd12;
    cyc();
    issue_valid = 1'b0; issue_rd = 5'd12; rs1_addr = 5'd12;
    ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'hC;
    cyc();
    ld_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'hD;
    #2 rst = 1'b1;
    #1 check("mid_rst_wr_en", {63'd0, reg_wr_en}, 64'd0);
    check("mid_rst_sb_err", {63'd0, sb_err}, 64'd0);
    check("mid_rst_wb_cnt", {32'd0, wb_cnt}, 64'd0);
    check("mid_rst_rs1_busy", {63'd0, rs1_busy}, 64'd0);
    check("mid_rst_issue_ready", {63'd0, issue_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0; alu_valid = 1'b0;
    cyc();
    cyc();
    #1 check("post_rst_wb_cnt", {32'd0, wb_cnt}, 64'd0);
    check("post_rst_sb_err", {63'd0, sb_err}, 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
